yari_mem_bridge: RTL and testbench
==================================

Name: yari_mem_bridge

Overview:
Sits directly downstream of the yari core's tagged memory port (mem_id/mem_address/mem_read/mem_write/mem_readdataid) and consumes its requests. It buffers requests in a small FIFO and issues them to a pipelined split-transaction backend (Avalon-style: waitrequest plus in-order readdatavalid). It tracks the id of every outstanding read and returns read data tagged with that id, so the core can steer data to the I-cache or D-cache.

Parameters:
REQ_DEPTH, 4, request FIFO entries (power of 2, >=2)
MAX_OUTSTANDING, 4, maximum backend reads in flight (power of 2, >=1)

Ports:
clock  in  1  core clock; every register samples on rising edge
rst  in  1  synchronous, active-high reset
mem_waitrequest  out  1  high = request this cycle not accepted
mem_id  in  2  requester tag (1=DC, 2=IC; 0 legal but means "discard data")
mem_address  in  30  word address
mem_read  in  1  read strobe
mem_write  in  1  write strobe
mem_writedata  in  32  write data
mem_writedatamask  in  4  byte enables, bit i = byte i
mem_readdata  out  32  returned read data
mem_readdataid  out  2  tag of mem_readdata; 0 = no data this cycle
bk_address  out  30  backend word address
bk_read  out  1  backend read strobe
bk_write  out  1  backend write strobe
bk_writedata  out  32  backend write data
bk_byteenable  out  4  backend byte enables
bk_waitrequest  in  1  backend stall; command held while high
bk_readdata  in  32  backend read data
bk_readdatavalid  in  1  backend read data valid, in request order
err_spurious  out  1  sticky: readdatavalid seen with no read outstanding

Behaviour:
- Reset (rst high at edge): both FIFOs empty; outstanding count 0. Outputs: mem_waitrequest=1 during the reset cycle and 0 afterwards. mem_readdataid=0, mem_readdata=0, bk_read=0, bk_write=0, err_spurious=0. A reset mid-transaction drops all queued and in-flight state. Backend data arriving after reset counts as spurious.
- Accept: mem_waitrequest is a registered full flag. A request is accepted when (mem_read|mem_write) & ~mem_waitrequest. Each accepted request pushes {write, id, address, writedata, mask} into the request FIFO.
- mem_read and mem_write both high: the request is treated as a write and the read is dropped.
- Full flag: mem_waitrequest rises the cycle after the push that fills the FIFO. It falls the cycle after a pop when no push occurred in the same cycle. A simultaneous push and pop when full cannot happen, because there is no push while full.
- Issue: the FIFO head drives the bk_* outputs directly from registers; there is no combinational path from mem_* to bk_*.
  - Minimum latency is 1 cycle: a request accepted at edge N appears on bk_* during cycle N+1.
  - A head entry is popped at an edge where bk_write|bk_read is high and bk_waitrequest is low.
  - A read head is presented (bk_read=1) only if the outstanding count < MAX_OUTSTANDING. Otherwise bk_read=0 and the FIFO stalls, with no bypass of later writes (strict order).
  - While bk_waitrequest is high, all bk_* outputs stay stable.
- Id tracking: each issued read pushes its id into an id FIFO of depth MAX_OUTSTANDING. Each bk_readdatavalid pops the id FIFO.
  - The outstanding count increments on issue and decrements on data; if both happen in the same cycle the count is unchanged.
- Return path (registered, 1 cycle): at the edge after bk_readdatavalid, mem_readdata=bk_readdata and mem_readdataid=the popped id. In every other cycle mem_readdataid=0 and mem_readdata holds its last value. Back-to-back valids produce back-to-back returns.
- Spurious data: bk_readdatavalid with outstanding count 0 sets err_spurious. err_spurious is cleared only by rst. No return is produced and the id FIFO is not popped.
- Writes return nothing and do not use the id FIFO.

Test Plan:
- Single read: accept read id=1 addr=0x0000100 at edge 0 → bk_read=1, bk_address=0x0000100 in cycle 1. Backend returns 0xDEADBEEF with valid at edge 4 → mem_readdata=0xDEADBEEF, mem_readdataid=1 in cycle 5 only.
- Order and tags: reads with ids 2,1,2 accepted back-to-back, backend returns A,B,C → readdataid sequence 2,1,2 paired with A,B,C. No bubbles between returns when the valids are consecutive.
- Backpressure: hold bk_waitrequest=1 and issue 4 writes → mem_waitrequest=1 from the cycle after the 4th accept. bk_* stay stable. Release → 4 writes appear in order with mask 4'b0011 preserved on the 2nd.
- Outstanding limit: 5 reads with no data returned → only 4 bk_read handshakes occur. The 5th issues exactly one cycle after the first bk_readdatavalid.
- Read+write both high with data 0x12345678, id=2 → exactly one bk_write and no read return.
- Spurious and reset: bk_readdatavalid with nothing outstanding → err_spurious=1 and mem_readdataid stays 0. Then rst mid-burst with 2 reads outstanding → all outputs return to reset values and err_spurious=0.

Source files
------------

// File: rtl/yari_mem_bridge.sv
// Bridges the yari tagged memory port to an in-order split-transaction backend, returning read data tagged with its id.
// Latency: 1 cycle request->bk_*, 1 cycle readdatavalid->return; backpressure: mem_waitrequest on full FIFO, bk_* held under bk_waitrequest.
module yari_mem_bridge #(
    parameter int REQ_DEPTH       = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clock,
    input  logic        rst,
    output logic        mem_waitrequest,
    input  logic [1:0]  mem_id,
    input  logic [29:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_writedata,
    input  logic [3:0]  mem_writedatamask,
    output logic [31:0] mem_readdata,
    output logic [1:0]  mem_readdataid,
    output logic [29:0] bk_address,
    output logic        bk_read,
    output logic        bk_write,
    output logic [31:0] bk_writedata,
    output logic [3:0]  bk_byteenable,
    input  logic        bk_waitrequest,
    input  logic [31:0] bk_readdata,
    input  logic        bk_readdatavalid,
    output logic        err_spurious
);
    localparam int RAW = $clog2(REQ_DEPTH);
    localparam int RCW = $clog2(REQ_DEPTH + 1);
    localparam int IAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [RCW-1:0] REQ_FULL = RCW'(REQ_DEPTH);
    localparam logic [OCW-1:0] OUT_MAX  = OCW'(MAX_OUTSTANDING);

    typedef struct packed {
        logic        write;
        logic [1:0]  id;
        logic [29:0] address;
        logic [31:0] writedata;
        logic [3:0]  mask;
    } req_t;

    req_t           req_mem [REQ_DEPTH];
    logic [RAW-1:0] req_wr;
    logic [RAW-1:0] req_rd;
    logic [RCW-1:0] req_cnt;
    logic [RCW-1:0] req_cnt_nxt;
    logic           full_q;

    // Sized to a power of two so a single-entry tracker still has a usable pointer.
    logic [1:0]     id_mem [2**IAW];
    logic [IAW-1:0] id_wr;
    logic [IAW-1:0] id_rd;
    logic [OCW-1:0] out_cnt;

    req_t head;
    req_t push_ent;
    logic push;
    logic pop;
    logic issue_rd;
    logic rd_ok;

    assign mem_waitrequest = full_q | rst;
    assign push = (mem_read | mem_write) & ~mem_waitrequest;
    // A simultaneous read+write strobe is carried as a write only.
    assign push_ent = '{write: mem_write, id: mem_id, address: mem_address,
                        writedata: mem_writedata, mask: mem_writedatamask};

    assign head          = req_mem[req_rd];
    assign bk_write      = (req_cnt != '0) & head.write;
    assign bk_read       = (req_cnt != '0) & ~head.write & (out_cnt < OUT_MAX);
    assign bk_address    = head.address;
    assign bk_writedata  = head.writedata;
    assign bk_byteenable = head.mask;

    assign pop      = (bk_read | bk_write) & ~bk_waitrequest;
    assign issue_rd = bk_read & ~bk_waitrequest;
    assign rd_ok    = bk_readdatavalid & (out_cnt != '0);

    always_comb begin
        req_cnt_nxt = req_cnt;
        if (push && !pop) begin
            req_cnt_nxt = req_cnt + RCW'(1);
        end else if (!push && pop) begin
            req_cnt_nxt = req_cnt - RCW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            req_mem[req_wr] <= push_ent;
        end
        if (issue_rd) begin
            id_mem[id_wr] <= head.id;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            req_wr         <= '0;
            req_rd         <= '0;
            req_cnt        <= '0;
            full_q         <= 1'b0;
            id_wr          <= '0;
            id_rd          <= '0;
            out_cnt        <= '0;
            mem_readdata   <= '0;
            mem_readdataid <= '0;
            err_spurious   <= 1'b0;
        end else begin
            if (push) begin
                req_wr <= req_wr + RAW'(1);
            end
            if (pop) begin
                req_rd <= req_rd + RAW'(1);
            end
            req_cnt <= req_cnt_nxt;
            full_q  <= (req_cnt_nxt == REQ_FULL);
            if (issue_rd) begin
                id_wr <= id_wr + IAW'(1);
            end
            if (rd_ok) begin
                id_rd <= id_rd + IAW'(1);
            end
            case ({issue_rd, rd_ok})
                2'b10:   out_cnt <= out_cnt + OCW'(1);
                2'b01:   out_cnt <= out_cnt - OCW'(1);
                default: out_cnt <= out_cnt;
            endcase
            mem_readdataid <= rd_ok ? id_mem[id_rd] : 2'd0;
            if (rd_ok) begin
                mem_readdata <= bk_readdata;
            end
            if (bk_readdatavalid && out_cnt == '0) begin
                err_spurious <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_yari_mem_bridge.sv
// Bench for yari_mem_bridge: queue-level reference model checked every cycle, plus directed literal checks.
module tb_yari_mem_bridge;
    localparam int REQ_DEPTH = 4;
    localparam int MAX_OUT   = 4;

    logic        clock;
    logic        rst;
    logic        mem_waitrequest;
    logic [1:0]  mem_id;
    logic [29:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_writedatamask;
    logic [31:0] mem_readdata;
    logic [1:0]  mem_readdataid;
    logic [29:0] bk_address;
    logic        bk_read;
    logic        bk_write;
    logic [31:0] bk_writedata;
    logic [3:0]  bk_byteenable;
    logic        bk_waitrequest;
    logic [31:0] bk_readdata;
    logic        bk_readdatavalid;
    logic        err_spurious;

    yari_mem_bridge #(.REQ_DEPTH(REQ_DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clock(clock), .rst(rst), .mem_waitrequest(mem_waitrequest), .mem_id(mem_id),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_writedatamask(mem_writedatamask),
        .mem_readdata(mem_readdata), .mem_readdataid(mem_readdataid),
        .bk_address(bk_address), .bk_read(bk_read), .bk_write(bk_write),
        .bk_writedata(bk_writedata), .bk_byteenable(bk_byteenable),
        .bk_waitrequest(bk_waitrequest), .bk_readdata(bk_readdata),
        .bk_readdatavalid(bk_readdatavalid), .err_spurious(err_spurious)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
        end else begin
            passes++;
        end
    endfunction

    // Reference model: pending requests and ids of reads in flight as plain queues.
    typedef struct {
        bit        w;
        bit [1:0]  id;
        bit [29:0] a;
        bit [31:0] d;
        bit [3:0]  m;
    } mreq_t;

    mreq_t     q[$];
    bit [1:0]  ids[$];
    bit [1:0]  m_rid   = 0;
    bit [31:0] m_rdata = 0;
    bit        m_err   = 0;
    bit        started = 0;
    bit        ew;
    bit        er;
    bit        acc;
    mreq_t     nreq;

    always @(posedge clock) begin
        if (rst) begin
            q.delete();
            ids.delete();
            m_rid   = 0;
            m_rdata = 0;
            m_err   = 0;
            started = 1;
        end else begin
            ew  = (q.size() > 0) && q[0].w;
            er  = (q.size() > 0) && !q[0].w && (ids.size() < MAX_OUT);
            acc = (mem_read || mem_write) && (q.size() != REQ_DEPTH);
            m_rid = 0;
            if (bk_readdatavalid) begin
                if (ids.size() > 0) begin
                    m_rid   = ids.pop_front();
                    m_rdata = bk_readdata;
                end else begin
                    m_err = 1;
                end
            end
            if ((ew || er) && !bk_waitrequest) begin
                if (er) ids.push_back(q[0].id);
                void'(q.pop_front());
            end
            if (acc) begin
                nreq.w = mem_write;
                nreq.id = mem_id;
                nreq.a = mem_address;
                nreq.d = mem_writedata;
                nreq.m = mem_writedatamask;
                q.push_back(nreq);
            end
        end
    end

    bit e_w;
    bit e_r;
    always @(negedge clock) begin
        if (started) begin
            e_w = (q.size() > 0) && q[0].w;
            e_r = (q.size() > 0) && !q[0].w && (ids.size() < MAX_OUT);
            chk("mem_waitrequest", 32'(mem_waitrequest), 32'(rst || (q.size() == REQ_DEPTH)));
            chk("bk_write", 32'(bk_write), 32'(e_w));
            chk("bk_read", 32'(bk_read), 32'(e_r));
            if (e_w || e_r) chk("bk_address", 32'(bk_address), 32'(q[0].a));
            if (e_w) begin
                chk("bk_writedata", bk_writedata, q[0].d);
                chk("bk_byteenable", 32'(bk_byteenable), 32'(q[0].m));
            end
            chk("mem_readdataid", 32'(mem_readdataid), 32'(m_rid));
            chk("mem_readdata", mem_readdata, m_rdata);
            chk("err_spurious", 32'(err_spurious), 32'(m_err));
        end
    end

    int rd_hs = 0;
    int wr_hs = 0;
    always @(negedge clock) begin
        if (!rst && bk_read && !bk_waitrequest) rd_hs++;
        if (!rst && bk_write && !bk_waitrequest) wr_hs++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit r, input bit w, input bit [1:0] id, input bit [29:0] a,
                         input bit [31:0] d, input bit [3:0] m);
        mem_read = r;
        mem_write = w;
        mem_id = id;
        mem_address = a;
        mem_writedata = d;
        mem_writedatamask = m;
    endtask

    logic [31:0] rvals [3];
    logic [1:0]  rids  [3];
    int base;
    int rbase;

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        bk_waitrequest = 1'b0;
        bk_readdata = '0;
        bk_readdatavalid = 1'b0;
        step();
        @(negedge clock);
        chk("reset_waitreq_hi", 32'(mem_waitrequest), 32'd1);
        step();
        rst = 1'b0;
        @(negedge clock);
        chk("post_reset_waitreq", 32'(mem_waitrequest), 32'd0);
        chk("post_reset_bk_read", 32'(bk_read), 32'd0);
        chk("post_reset_bk_write", 32'(bk_write), 32'd0);
        chk("post_reset_rid", 32'(mem_readdataid), 32'd0);
        chk("post_reset_rdata", mem_readdata, 32'd0);
        chk("post_reset_err", 32'(err_spurious), 32'd0);

        // Single read
        step();
        drive(1, 0, 2'd1, 30'h0000100, 0, 4'hf);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("single_bk_read", 32'(bk_read), 32'd1);
        chk("single_bk_addr", 32'(bk_address), 32'h100);
        step();
        step();
        step();
        bk_readdatavalid = 1'b1;
        bk_readdata = 32'hDEADBEEF;
        step();
        bk_readdatavalid = 1'b0;
        @(negedge clock);
        chk("single_rid", 32'(mem_readdataid), 32'd1);
        chk("single_rdata", mem_readdata, 32'hDEADBEEF);
        step();
        @(negedge clock);
        chk("single_rid_once", 32'(mem_readdataid), 32'd0);
        chk("single_rdata_hold", mem_readdata, 32'hDEADBEEF);

        // Order and tags
        rids[0] = 2'd2; rids[1] = 2'd1; rids[2] = 2'd2;
        rvals[0] = 32'hAAAA0001; rvals[1] = 32'hBBBB0002; rvals[2] = 32'hCCCC0003;
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, rids[i], 30'h10 + 30'(i), 0, 4'hf);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            bk_readdatavalid = 1'b1;
            bk_readdata = rvals[i];
            step();
            if (i == 2) bk_readdatavalid = 1'b0;
            @(negedge clock);
            chk("order_rid", 32'(mem_readdataid), 32'(rids[i]));
            chk("order_rdata", mem_readdata, rvals[i]);
        end
        step();
        @(negedge clock);
        chk("order_rid_idle", 32'(mem_readdataid), 32'd0);

        // Backpressure
        step();
        bk_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 2'd1, 30'h20 + 30'(i), 32'hA0000000 + 32'(i), (i == 1) ? 4'b0011 : 4'b1111);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("bp_full", 32'(mem_waitrequest), 32'd1);
        chk("bp_bk_write", 32'(bk_write), 32'd1);
        chk("bp_addr", 32'(bk_address), 32'h20);
        step();
        step();
        @(negedge clock);
        chk("bp_stable_addr", 32'(bk_address), 32'h20);
        chk("bp_stable_data", bk_writedata, 32'hA0000000);
        step();
        bk_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("bp_drain_addr", 32'(bk_address), 32'h20 + 32'(i));
            chk("bp_drain_mask", 32'(bk_byteenable), (i == 1) ? 32'h3 : 32'hf);
            step();
        end
        @(negedge clock);
        chk("bp_empty", 32'(bk_write), 32'd0);
        chk("bp_waitreq_low", 32'(mem_waitrequest), 32'd0);

        // Outstanding limit
        step();
        base = rd_hs;
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, (i % 2 == 1) ? 2'd2 : 2'd1, 30'h30 + 30'(i), 0, 4'hf);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        step();
        @(negedge clock);
        chk("lim_four_hs", 32'(rd_hs - base), 32'd4);
        chk("lim_stalled", 32'(bk_read), 32'd0);
        step();
        bk_readdatavalid = 1'b1;
        bk_readdata = 32'h5A5A0001;
        step();
        bk_readdatavalid = 1'b0;
        @(negedge clock);
        chk("lim_fifth_read", 32'(bk_read), 32'd1);
        chk("lim_fifth_addr", 32'(bk_address), 32'h34);
        chk("lim_first_rid", 32'(mem_readdataid), 32'd1);
        step();
        @(negedge clock);
        chk("lim_five_hs", 32'(rd_hs - base), 32'd5);
        step();
        for (int i = 0; i < 4; i++) begin
            bk_readdatavalid = 1'b1;
            bk_readdata = 32'h5A5A0002 + 32'(i);
            step();
        end
        bk_readdatavalid = 1'b0;
        @(negedge clock);
        chk("lim_last_rid", 32'(mem_readdataid), 32'd1);
        chk("lim_last_rdata", mem_readdata, 32'h5A5A0005);

        // Read and write strobes together
        step();
        base = wr_hs;
        rbase = rd_hs;
        drive(1, 1, 2'd2, 30'h40, 32'h12345678, 4'hf);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("rw_is_write", 32'(bk_write), 32'd1);
        chk("rw_no_read", 32'(bk_read), 32'd0);
        chk("rw_data", bk_writedata, 32'h12345678);
        step();
        step();
        step();
        @(negedge clock);
        chk("rw_one_write", 32'(wr_hs - base), 32'd1);
        chk("rw_zero_reads", 32'(rd_hs - rbase), 32'd0);

        // Spurious data, then reset with reads in flight
        step();
        bk_readdatavalid = 1'b1;
        bk_readdata = 32'h0BAD0BAD;
        step();
        bk_readdatavalid = 1'b0;
        @(negedge clock);
        chk("spur_err", 32'(err_spurious), 32'd1);
        chk("spur_rid", 32'(mem_readdataid), 32'd0);
        step();
        drive(1, 0, 2'd1, 30'h50, 0, 4'hf);
        step();
        drive(1, 0, 2'd2, 30'h51, 0, 4'hf);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        drive(1, 0, 2'd1, 30'h52, 0, 4'hf);
        rst = 1'b1;
        @(negedge clock);
        chk("rst_waitreq", 32'(mem_waitrequest), 32'd1);
        step();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("rst_err_clr", 32'(err_spurious), 32'd0);
        chk("rst_bk_read", 32'(bk_read), 32'd0);
        chk("rst_bk_write", 32'(bk_write), 32'd0);
        chk("rst_rid", 32'(mem_readdataid), 32'd0);
        chk("rst_rdata", mem_readdata, 32'd0);
        chk("rst_waitreq_low", 32'(mem_waitrequest), 32'd0);
        bk_readdatavalid = 1'b1;
        bk_readdata = 32'h77777777;
        step();
        bk_readdatavalid = 1'b0;
        @(negedge clock);
        chk("post_rst_spur", 32'(err_spurious), 32'd1);
        chk("post_rst_spur_rid", 32'(mem_readdataid), 32'd0);
        step();
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
